// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit for the EX stage.
// Owns HI/LO. MULT/MULTU use shift-add and DIV/DIVU use restoring division,
// one bit per cycle. Signed ops run on magnitudes and fix the signs at the end.
module ex_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic             a_neg, b_neg, divz;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;    // upper product half / partial remainder
    logic [WIDTH-1:0] mq;     // multiplier (shifted out) / dividend -> quotient
    logic [WIDTH-1:0] mcand;  // multiplicand / divisor magnitude

    logic             is_signed;
    logic [WIDTH-1:0] rs_abs, rt_abs;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic             div_ok;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign busy      = (state != IDLE);
    assign is_signed = ~op[0];

    // Operand magnitudes for the signed ops; unsigned ops pass through raw.
    always_comb begin
        rs_abs = (is_signed && rs_val[WIDTH-1]) ? (~rs_val + 1'b1) : rs_val;
        rt_abs = (is_signed && rt_val[WIDTH-1]) ? (~rt_val + 1'b1) : rt_val;
    end

    // One iteration of shift-add and of restoring division.
    // A zero divisor is forced to "subtract succeeds" so the remainder ends up
    // as the untouched dividend; the quotient is overridden at FIX anyway.
    always_comb begin
        mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
        div_sh   = {acc, mq[WIDTH-1]};
        div_diff = div_sh - {1'b0, mcand};
        div_ok   = ~div_diff[WIDTH] | divz;
    end

    // Final sign correction of the magnitude results.
    always_comb begin
        prod     = {acc, mq};
        prod_fix = (a_neg ^ b_neg) ? (~prod + 1'b1) : prod;
        quo_fix  = (a_neg ^ b_neg) ? (~mq + 1'b1) : mq;
        rem_fix  = a_neg ? (~acc + 1'b1) : acc;
    end

    // Control FSM plus datapath, HI/LO and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            divz  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            mq    <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_neg <= is_signed & rs_val[WIDTH-1];
                        b_neg <= is_signed & rt_val[WIDTH-1];
                        divz  <= op[1] & (rt_val == '0);
                        acc   <= '0;
                        mq    <= rs_abs;
                        mcand <= rt_abs;
                        // rs is the multiplicand: put rt in mq so it shifts out
                        if (!op[1]) begin
                            mq    <= rt_abs;
                            mcand <= rs_abs;
                        end
                        cnt   <= CW'(WIDTH - 1);
                        state <= RUN;
                    end else begin
                        if (mthi_we) hi <= wdata;
                        if (mtlo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    if (op_q[1]) begin
                        acc <= div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        mq  <= {mq[WIDTH-2:0], div_ok};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    if (op_q[1]) begin
                        lo <= divz ? '1 : quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: products, quotients, divide-by-zero, overflow,
// MTHI/MTLO priority, start-while-busy and reset abort.
module tb_ex_mdu;
    logic        clk, reset, start, mthi_we, mtlo_we, busy, done;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wdata, hi, lo;
    int checks = 0;
    int failures = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    ex_mdu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one start cycle; returns at the first negedge after the launch edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles (pre already elapsed), then check result and done pulse.
    task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el,
                             input int pre);
        int n = pre;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_cycles"}, n, 33);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        @(negedge clk);
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dn;
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        launch(MULTU, 32'hFFFF_FFFF, 32'd2);
        chk("multu_busy", {31'd0, busy}, 32'd1);
        wait_done("multu", 32'h0000_0001, 32'hFFFF_FFFE, 0);

        launch(MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        launch(MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9);
        wait_done("mult_pos", 32'd0, 32'd21, 0);

        launch(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        launch(DIVU, 32'd100, 32'd7);
        wait_done("divu", 32'd2, 32'd14, 0);

        launch(DIVU, 32'h0000_1234, 32'd0);
        wait_done("divu_z", 32'h0000_1234, 32'hFFFF_FFFF, 0);
        launch(DIV, 32'hFFFF_FFFB, 32'd0);
        wait_done("div_z", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 32'd0, 32'h8000_0000, 0);

        // MT writes while idle
        mthi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi_we = 1'b0;
        chk("mthi_hi", hi, 32'hA5A5_A5A5);
        chk("mthi_lo", lo, 32'h8000_0000);
        chk("mthi_done", {31'd0, done}, 32'd0);
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h0000_1357;
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        chk("mtboth_hi", hi, 32'h0000_1357);
        chk("mtboth_lo", lo, 32'h0000_1357);
        mthi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi_we = 1'b0;

        // MTHI and a second start mid-RUN must both be ignored
        launch(MULTU, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        mthi_we = 1'b1; wdata = 32'h1111_2222; start = 1'b1; op = DIVU;
        rs_val = 32'd100; rt_val = 32'd0;
        @(negedge clk);
        mthi_we = 1'b0; start = 1'b0;
        chk("midrun_hi_held", hi, 32'hA5A5_A5A5);
        chk("midrun_lo_held", lo, 32'h0000_1357);
        wait_done("midrun", 32'd0, 32'd15, 5);

        // start beats mtlo_we in the same idle cycle
        mtlo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        launch(DIVU, 32'd100, 32'd7);
        mtlo_we = 1'b0;
        wait_done("start_prio", 32'd2, 32'd14, 0);

        // reset aborts an op in flight
        launch(DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("abort_no_done", dn, 32'd0);
        launch(MULTU, 32'd3, 32'd5);
        wait_done("post_rst", 32'd0, 32'd15, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
